ppi8255: RTL and testbench



---
 rtl/ppi8255_pkg.sv | 35 +++
 rtl/ppi8255_mode1a.sv | 81 ++++++++
 rtl/ppi8255.sv | 138 +++++++++++++
 tb/tb_ppi8255.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ppi8255_pkg.sv
// rtl/ppi8255_pkg.sv - register map, control bit indices and handshake pin positions for ppi8255
package ppi8255_pkg;

    localparam logic [1:0] PPI_PA   = 2'd0;
    localparam logic [1:0] PPI_PB   = 2'd1;
    localparam logic [1:0] PPI_PC   = 2'd2;
    localparam logic [1:0] PPI_CTRL = 2'd3;

    localparam int CTRL_MODESET = 7;
    localparam int CTRL_GA_HI   = 6;
    localparam int CTRL_GA_LO   = 5;
    localparam int CTRL_PA_IN   = 4;
    localparam int CTRL_PCU_IN  = 3;
    localparam int CTRL_GB_MODE = 2;
    localparam int CTRL_PB_IN   = 1;
    localparam int CTRL_PCL_IN  = 0;

    localparam logic [2:0] PC_INTR_A  = 3'd3;
    localparam logic [2:0] PC_STB_A_N = 3'd4;
    localparam logic [2:0] PC_IBF_A   = 3'd5;
    localparam logic [2:0] PC_ACK_A_N = 3'd6;
    localparam logic [2:0] PC_OBF_A_N = 3'd7;

    localparam logic [7:0] PPI_CTRL_RESET = 8'h9B;

    typedef struct packed {
        logic inte;
        logic intr;
        logic ibf;
        logic obf_n;
    } m1_status_t;

    localparam m1_status_t M1_STATUS_RESET = '{inte: 1'b0, intr: 1'b0, ibf: 1'b0, obf_n: 1'b1};

endpackage

// File: rtl/ppi8255_mode1a.sv
// rtl/ppi8255_mode1a.sv - group A mode 1 strobed handshake (only instantiated under PPI_MODE1_EN)
module ppi8255_mode1a
    import ppi8255_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_in,
    input  logic       mode_out,
    input  logic       mode_set,
    input  logic       pa_rd,
    input  logic       pa_wr,
    input  logic       bsr_wr,
    input  logic [2:0] bsr_bit,
    input  logic       bsr_val,
    input  logic       stb_n,
    input  logic       ack_n,
    input  logic [7:0] pa_pin,
    output m1_status_t status,
    output logic [7:0] pa_latch
);

    logic       stb_q1, stb_q2, ack_q1, ack_q2;
    logic [7:0] pa_q1;
    m1_status_t st_q, st_d;
    logic [7:0] latch_q, latch_d;
    logic       stb_fall, stb_rise, ack_fall, ack_rise;

    // q1 is the synchronised pin, q2 the previous sample used for edge detection
    assign stb_fall = stb_q2 & ~stb_q1;
    assign stb_rise = ~stb_q2 & stb_q1;
    assign ack_fall = ack_q2 & ~ack_q1;
    assign ack_rise = ~ack_q2 & ack_q1;

    always_comb begin
        st_d    = st_q;
        latch_d = latch_q;
        if (mode_set) begin
            st_d = M1_STATUS_RESET;
        end else if (mode_in) begin
            if (bsr_wr && bsr_bit == PC_STB_A_N) st_d.inte = bsr_val;
            if (stb_fall) begin
                st_d.ibf = 1'b1;
                latch_d  = pa_q1;
            end else if (pa_rd) begin
                st_d.ibf = 1'b0;
            end
            if (stb_rise && st_q.inte) st_d.intr = 1'b1;
            else if (pa_rd)            st_d.intr = 1'b0;
        end else if (mode_out) begin
            if (bsr_wr && bsr_bit == PC_ACK_A_N) st_d.inte = bsr_val;
            if (pa_wr)         st_d.obf_n = 1'b0;
            else if (ack_fall) st_d.obf_n = 1'b1;
            if (ack_rise && st_q.inte) st_d.intr = 1'b1;
            else if (pa_wr)            st_d.intr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q1  <= 1'b1;
            stb_q2  <= 1'b1;
            ack_q1  <= 1'b1;
            ack_q2  <= 1'b1;
            pa_q1   <= '0;
            st_q    <= M1_STATUS_RESET;
            latch_q <= '0;
        end else begin
            stb_q1  <= stb_n;
            stb_q2  <= stb_q1;
            ack_q1  <= ack_n;
            ack_q2  <= ack_q1;
            pa_q1   <= pa_pin;
            st_q    <= st_d;
            latch_q <= latch_d;
        end
    end

    assign status   = st_q;
    assign pa_latch = latch_q;

endmodule

// File: rtl/ppi8255.sv
// rtl/ppi8255.sv - 8255 PPI with control register and BSR; group A mode 1 under PPI_MODE1_EN
module ppi8255
    import ppi8255_pkg::*;
#(
    parameter logic [7:0] CTRL_RESET = PPI_CTRL_RESET,
    parameter logic [7:0] PA_RESET   = 8'h00,
    parameter logic [7:0] PB_RESET   = 8'h00,
    parameter logic [7:0] PC_RESET   = 8'h00
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rnw,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    input  logic [7:0] pc_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pc_out,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    output logic [7:0] pc_oe
);

    logic [7:0] ctrl_q, pa_q, pb_q, pc_q;
    logic       wr, rd, ctrl_wr, mode_set, bsr_wr;
    logic       m1_in, m1_out;
    m1_status_t m1;
    logic [7:0] pa_latch;
    logic [7:0] pc_rd;
    logic       unused_ctrl;

    assign wr       = cs & ~rnw;
    assign rd       = cs & rnw;
    assign ctrl_wr  = wr && addr == PPI_CTRL;
    assign mode_set = ctrl_wr & din[CTRL_MODESET];
    assign bsr_wr   = ctrl_wr & ~din[CTRL_MODESET];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= CTRL_RESET;
            pa_q   <= PA_RESET;
            pb_q   <= PB_RESET;
            pc_q   <= PC_RESET;
        end else if (mode_set) begin
            ctrl_q <= din;
            pa_q   <= '0;
            pb_q   <= '0;
            pc_q   <= '0;
        end else if (bsr_wr) begin
            pc_q[din[3:1]] <= din[0];
        end else if (wr) begin
            case (addr)
                PPI_PA:  pa_q <= din;
                PPI_PB:  pb_q <= din;
                default: pc_q <= din;
            endcase
        end
    end

`ifdef PPI_MODE1_EN
    // modes 2'b1x fall back to mode 0
    assign m1_in  = ctrl_q[CTRL_GA_HI:CTRL_GA_LO] == 2'b01 &&  ctrl_q[CTRL_PA_IN];
    assign m1_out = ctrl_q[CTRL_GA_HI:CTRL_GA_LO] == 2'b01 && !ctrl_q[CTRL_PA_IN];
    assign unused_ctrl = ctrl_q[CTRL_GB_MODE];

    ppi8255_mode1a u_mode1a (
        .clk      (clk),
        .reset    (reset),
        .mode_in  (m1_in),
        .mode_out (m1_out),
        .mode_set (mode_set),
        .pa_rd    (rd && addr == PPI_PA),
        .pa_wr    (wr && addr == PPI_PA),
        .bsr_wr   (bsr_wr),
        .bsr_bit  (din[3:1]),
        .bsr_val  (din[0]),
        .stb_n    (pc_in[PC_STB_A_N]),
        .ack_n    (pc_in[PC_ACK_A_N]),
        .pa_pin   (pa_in),
        .status   (m1),
        .pa_latch (pa_latch)
    );
`else
    assign m1_in       = 1'b0;
    assign m1_out      = 1'b0;
    assign m1          = M1_STATUS_RESET;
    assign pa_latch    = '0;
    assign unused_ctrl = ^{ctrl_q[CTRL_GB_MODE], ctrl_q[CTRL_GA_HI:CTRL_GA_LO]};
`endif

    assign pa_out = pa_q;
    assign pb_out = pb_q;
    assign pa_oe  = ctrl_q[CTRL_PA_IN] ? 8'h00 : 8'hFF;
    assign pb_oe  = ctrl_q[CTRL_PB_IN] ? 8'h00 : 8'hFF;

    // handshake positions carry live status; the strobe/ack position reads back INTE
    always_comb begin
        pc_out = pc_q;
        pc_oe  = {{4{~ctrl_q[CTRL_PCU_IN]}}, {4{~ctrl_q[CTRL_PCL_IN]}}};
        pc_rd  = {ctrl_q[CTRL_PCU_IN] ? pc_in[7:4] : pc_q[7:4],
                  ctrl_q[CTRL_PCL_IN] ? pc_in[3:0] : pc_q[3:0]};
        if (m1_in) begin
            pc_out[PC_IBF_A]  = m1.ibf;
            pc_out[PC_INTR_A] = m1.intr;
            pc_oe[PC_IBF_A]   = 1'b1;
            pc_oe[PC_INTR_A]  = 1'b1;
            pc_oe[PC_STB_A_N] = 1'b0;
            pc_rd[PC_IBF_A]   = m1.ibf;
            pc_rd[PC_INTR_A]  = m1.intr;
            pc_rd[PC_STB_A_N] = m1.inte;
        end
        if (m1_out) begin
            pc_out[PC_OBF_A_N] = m1.obf_n;
            pc_out[PC_INTR_A]  = m1.intr;
            pc_oe[PC_OBF_A_N]  = 1'b1;
            pc_oe[PC_INTR_A]   = 1'b1;
            pc_oe[PC_ACK_A_N]  = 1'b0;
            pc_rd[PC_OBF_A_N]  = m1.obf_n;
            pc_rd[PC_INTR_A]   = m1.intr;
            pc_rd[PC_ACK_A_N]  = m1.inte;
        end
    end

    always_comb begin
        dout = ctrl_q;
        case (addr)
            PPI_PA:  dout = m1_in ? pa_latch : (ctrl_q[CTRL_PA_IN] ? pa_in : pa_q);
            PPI_PB:  dout = ctrl_q[CTRL_PB_IN] ? pb_in : pb_q;
            PPI_PC:  dout = pc_rd;
            default: dout = ctrl_q;
        endcase
    end

endmodule

// File: tb/tb_ppi8255.sv
// tb/tb_ppi8255.sv - scoreboard bench for ppi8255 against a behavioural model (honours PPI_MODE1_EN)
module tb_ppi8255;

`ifdef PPI_MODE1_EN
    localparam bit MODE1 = 1'b1;
`else
    localparam bit MODE1 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, cs, rnw;
    logic [1:0] addr;
    logic [7:0] din, dout, pa_in, pb_in, pc_in;
    logic [7:0] pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe;

    always #5 clk = ~clk;

    ppi8255 dut (
        .clk(clk), .reset(reset), .cs(cs), .rnw(rnw), .addr(addr), .din(din), .dout(dout),
        .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
        .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
        .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe(pc_oe)
    );

    typedef struct packed {
        logic [7:0] dout, pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference state: register contents, handshake flags, and the pin values seen at past edges
    logic [7:0] m_ctrl, m_pa, m_pb, m_pc, m_latch, pa_seen;
    bit         m_inte, m_intr, m_ibf, m_obf_n;
    bit   [1:0] stb_seen, ack_seen;
    logic [7:0] pa_pin, pb_pin, pc_pin;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t       e;
        bit         hs_in, hs_out;
        logic [7:0] pcv;
        hs_in  = MODE1 && m_ctrl[6:5] == 2'b01 && m_ctrl[4];
        hs_out = MODE1 && m_ctrl[6:5] == 2'b01 && !m_ctrl[4];
        e.pa_out = m_pa;
        e.pb_out = m_pb;
        e.pc_out = m_pc;
        e.pa_oe  = m_ctrl[4] ? 8'h00 : 8'hFF;
        e.pb_oe  = m_ctrl[1] ? 8'h00 : 8'hFF;
        e.pc_oe  = {(m_ctrl[3] ? 4'h0 : 4'hF), (m_ctrl[0] ? 4'h0 : 4'hF)};
        pcv      = {(m_ctrl[3] ? pc_in[7:4] : m_pc[7:4]), (m_ctrl[0] ? pc_in[3:0] : m_pc[3:0])};
        if (hs_in) begin
            e.pc_out[5] = m_ibf;  e.pc_out[3] = m_intr;
            e.pc_oe[5] = 1'b1; e.pc_oe[3] = 1'b1; e.pc_oe[4] = 1'b0;
            pcv[5] = m_ibf; pcv[4] = m_inte; pcv[3] = m_intr;
        end
        if (hs_out) begin
            e.pc_out[7] = m_obf_n; e.pc_out[3] = m_intr;
            e.pc_oe[7] = 1'b1; e.pc_oe[3] = 1'b1; e.pc_oe[6] = 1'b0;
            pcv[7] = m_obf_n; pcv[6] = m_inte; pcv[3] = m_intr;
        end
        case (addr)
            2'd0:    e.dout = hs_in ? m_latch : (m_ctrl[4] ? pa_in : m_pa);
            2'd1:    e.dout = m_ctrl[1] ? pb_in : m_pb;
            2'd2:    e.dout = pcv;
            default: e.dout = m_ctrl;
        endcase
        return e;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit rw, input logic [1:0] a, input logic [7:0] d);
        bit hs_in, hs_out, pa_rd, pa_wr, inte_old;
        if (r) begin
            m_ctrl = 8'h9B; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00; m_latch = 8'h00;
            m_inte = 0; m_intr = 0; m_ibf = 0; m_obf_n = 1;
            stb_seen = 2'b11; ack_seen = 2'b11; pa_seen = 8'h00;
            return;
        end
        hs_in    = MODE1 && m_ctrl[6:5] == 2'b01 && m_ctrl[4];
        hs_out   = MODE1 && m_ctrl[6:5] == 2'b01 && !m_ctrl[4];
        pa_rd    = c && rw && a == 2'd0;
        pa_wr    = c && !rw && a == 2'd0;
        inte_old = m_inte;
        if (c && !rw && a == 2'd3 && d[7]) begin
            m_ctrl = d; m_pa = 0; m_pb = 0; m_pc = 0;
            m_inte = 0; m_intr = 0; m_ibf = 0; m_obf_n = 1;
        end else begin
            if (c && !rw) begin
                case (a)
                    2'd0: m_pa = d;
                    2'd1: m_pb = d;
                    2'd2: m_pc = d;
                    default: begin
                        m_pc[d[3:1]] = d[0];
                        if (hs_in && d[3:1] == 3'd4) m_inte = d[0];
                        if (hs_out && d[3:1] == 3'd6) m_inte = d[0];
                    end
                endcase
            end
            if (hs_in) begin
                if (stb_seen == 2'b10) begin m_ibf = 1; m_latch = pa_seen; end
                else if (pa_rd) m_ibf = 0;
                if (stb_seen == 2'b01 && inte_old) m_intr = 1;
                else if (pa_rd) m_intr = 0;
            end
            if (hs_out) begin
                if (pa_wr) m_obf_n = 0;
                else if (ack_seen == 2'b10) m_obf_n = 1;
                if (ack_seen == 2'b01 && inte_old) m_intr = 1;
                else if (pa_wr) m_intr = 0;
            end
        end
        stb_seen = {stb_seen[0], pc_in[4]};
        ack_seen = {ack_seen[0], pc_in[6]};
        pa_seen  = pa_in;
    endtask

    task automatic cyc(input bit r, input bit c, input bit rw, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = r; cs = c; rnw = rw; addr = a; din = d;
        pa_in = pa_pin; pb_in = pb_pin; pc_in = pc_pin;
        sb.push_back(model_out());
        @(posedge clk);
        model_step(r, c, rw, a, d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d); cyc(0, 1, 0, a, d); endtask
    task automatic rd(input logic [1:0] a); cyc(0, 1, 1, a, 8'($urandom)); endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 1'($urandom), 2'($urandom), 8'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dout",   dout,   e.dout);
                chk("pa_out", pa_out, e.pa_out);
                chk("pb_out", pb_out, e.pb_out);
                chk("pc_out", pc_out, e.pc_out);
                chk("pa_oe",  pa_oe,  e.pa_oe);
                chk("pb_oe",  pb_oe,  e.pb_oe);
                chk("pc_oe",  pc_oe,  e.pc_oe);
            end
        end
    end

    initial begin : driver
        logic [7:0] d;
        int         op;
        pa_pin = 8'h00; pb_pin = 8'h00; pc_pin = 8'hFF;
        reset = 1; cs = 0; rnw = 1; addr = 0; din = 0; pa_in = 0; pb_in = 0; pc_in = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        model_step(1, 0, 1, 2'd0, 8'h00);

        rd(2'd3);
        wr(2'd3, 8'h8A); wr(2'd0, 8'h55); pb_pin = 8'h3C; rd(2'd1); rd(2'd0);
        wr(2'd2, 8'hF0); wr(2'd3, 8'h07); wr(2'd3, 8'h0E); rd(2'd2);
        wr(2'd0, 8'hAA); wr(2'd3, 8'h80); rd(2'd0);

        wr(2'd3, 8'hB0); wr(2'd3, 8'h09);
        pa_pin = 8'h42; pc_pin[4] = 1'b0; idle(3);
        pa_pin = 8'h17; pc_pin[4] = 1'b1; idle(3);
        rd(2'd2); rd(2'd0); idle(1); rd(2'd2);

        wr(2'd3, 8'hA0); wr(2'd3, 8'h0D); wr(2'd0, 8'h99); idle(1);
        pc_pin[6] = 1'b0; idle(2); pc_pin[6] = 1'b1; idle(3); rd(2'd2);
        wr(2'd0, 8'h5A); idle(1);
        cyc(1, 0, 1, 2'd0, 8'h00); idle(2); rd(2'd2);

        for (int i = 0; i < 3000; i++) begin
            op     = $urandom_range(0, 9);
            pa_pin = 8'($urandom);
            pb_pin = 8'($urandom);
            pc_pin = (8'($urandom) & 8'hAF) | (pc_pin & 8'h50);
            if ($urandom_range(0, 2) == 0) pc_pin[4] = ~pc_pin[4];
            if ($urandom_range(0, 2) == 0) pc_pin[6] = ~pc_pin[6];
            d = 8'($urandom);
            case (op)
                0:       cyc($urandom_range(0, 15) == 0, 0, 1'($urandom), 2'($urandom), d);
                1, 2:    wr(2'($urandom), d);
                3:       begin d[7] = 1'b1; if ($urandom_range(0, 1) == 1) d[6:5] = 2'b01; wr(2'd3, d); end
                4:       begin d[7] = 1'b0; wr(2'd3, d); end
                5, 6, 7: rd(2'($urandom));
                default: idle(1);
            endcase
        end

        @(negedge clk);
        @(negedge clk);
        #4;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
